// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache. It returns the instruction combinationally on a hit.
// On a miss it stalls the PC and refills the whole line, word 0 first, over a req/valid handshake.
module icache_direct #(
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        fetch,
    input  logic        flush,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
);

    localparam int O  = $clog2(WORDS_PER_LINE);
    localparam int S  = $clog2(SETS);
    localparam int TW = 30 - O - S;
    localparam logic [O-1:0] LAST_WORD = O'(WORDS_PER_LINE - 1);

    typedef enum logic [0:0] {
        LOOKUP,
        REFILL
    } state_t;

    state_t state, state_next;

    logic [SETS-1:0] valid;
    logic [TW-1:0]   tags [SETS];
    logic [31:0]     data [SETS][WORDS_PER_LINE];

    logic [29-O:0]   line_base;
    logic [O-1:0]    count;

    logic [O-1:0]    offset;
    logic [S-1:0]    index;
    logic [TW-1:0]   pc_tag;
    logic [S-1:0]    refill_index;
    logic [TW-1:0]   refill_tag;
    logic            hit;
    logic            last;
    logic            refill_write;
    logic            unused_pc_bits;

    assign offset         = pc[O+1:2];
    assign index          = pc[O+S+1:O+2];
    assign pc_tag         = pc[31:O+S+2];
    assign unused_pc_bits = ^pc[1:0];

    // The latched line base holds both the refill set and its tag, so later pc changes do not matter.
    assign refill_index = line_base[S-1:0];
    assign refill_tag   = line_base[29-O:S];

    assign hit          = fetch && valid[index] && (tags[index] == pc_tag);
    assign last         = (count == LAST_WORD);
    assign refill_write = !rst && !flush && (state == REFILL) && mem_rvalid;

    assign instr    = data[index][offset];
    assign mem_addr = {line_base, count, 2'b00};

    always_comb begin
        state_next  = state;
        instr_valid = 1'b0;
        stall       = 1'b0;
        mem_req     = 1'b0;
        if (!rst) begin
            case (state)
                LOOKUP: begin
                    if (flush) begin
                        stall = fetch;
                    end else if (hit) begin
                        instr_valid = 1'b1;
                    end else if (fetch) begin
                        stall      = 1'b1;
                        state_next = REFILL;
                    end
                end
                REFILL: begin
                    stall   = 1'b1;
                    mem_req = 1'b1;
                    if (flush || (mem_rvalid && last)) begin
                        state_next = LOOKUP;
                    end
                end
                default: state_next = LOOKUP;
            endcase
        end
    end

    // A flush wins over a pending miss or refill beat, so no line can become valid in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOOKUP;
            valid <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            if (flush) begin
                valid <= '0;
                count <= '0;
            end else if (state == LOOKUP && fetch && !hit) begin
                line_base    <= pc[31:O+2];
                count        <= '0;
                valid[index] <= 1'b0;
            end else if (state == REFILL && mem_rvalid) begin
                count <= count + 1'b1;
                if (last) begin
                    valid[refill_index] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (refill_write) begin
            data[refill_index][count] <= mem_rdata;
            if (last) begin
                tags[refill_index] <= refill_tag;
            end
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct. A behavioural backing memory has a programmable latency.
// Each check goes through checkOutput and is compared against hand-computed values.
module tb_icache_direct;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        fetch;
    logic        flush;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          mem_lat = 1;
    int          wait_cnt = 0;
    logic [31:0] held_addr = '0;
    logic [31:0] addr_log [$];
    int          n;

    icache_direct #(.SETS(16), .WORDS_PER_LINE(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .fetch       (fetch),
        .flush       (flush),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'hBFC00000: return 32'h00000013;
            32'hBFC00004: return 32'h00500093;
            32'hBFC00008: return 32'h00A00113;
            32'hBFC0000C: return 32'h002081B3;
            default:      return a + 32'h10000000;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Memory answers each word on the mem_lat-th cycle it is requested and must see a steady address meanwhile.
    always @(negedge clk) begin
        #1;
        if (mem_req) begin
            if (wait_cnt == 0) begin
                held_addr = mem_addr;
            end else begin
                checkOutput("addr_hold", mem_addr, held_addr);
            end
            if (wait_cnt == mem_lat - 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = memWord(mem_addr);
                addr_log.push_back(mem_addr);
                wait_cnt   = 0;
            end else begin
                mem_rvalid = 1'b0;
                wait_cnt   = wait_cnt + 1;
            end
        end else begin
            mem_rvalid = 1'b0;
            wait_cnt   = 0;
        end
    end

    task automatic applyStimulus(input logic f, input logic [31:0] a, input logic fl, input logic r);
        @(negedge clk);
        fetch = f;
        pc    = a;
        flush = fl;
        rst   = r;
        #2;
    endtask

    // Holds the fetch until it hits (bounded), then checks the stall count and the delivered word.
    task automatic fetchLine(input string tag, input logic [31:0] a, input logic [31:0] exp_instr,
                             input int exp_stalls);
        int cnt;
        cnt = 0;
        applyStimulus(1'b1, a, 1'b0, 1'b0);
        while (stall && cnt < 200) begin
            cnt++;
            applyStimulus(1'b1, a, 1'b0, 1'b0);
        end
        checkOutput({tag, "_stalls"}, 32'(cnt), 32'(exp_stalls));
        checkOutput({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
        checkOutput({tag, "_instr"}, instr, exp_instr);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; fetch = 1'b0; flush = 1'b0; pc = '0;
        mem_rdata = '0; mem_rvalid = 1'b0;

        applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b1);
        checkOutput("rst_stall", {31'b0, stall}, 32'd0);
        checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("rst_req", {31'b0, mem_req}, 32'd0);
        applyStimulus(1'b0, 32'hBFC00000, 1'b0, 1'b0);
        checkOutput("idle_stall", {31'b0, stall}, 32'd0);
        checkOutput("idle_valid", {31'b0, instr_valid}, 32'd0);

        // Cold miss, then hit
        applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b0);
        checkOutput("miss_stall", {31'b0, stall}, 32'd1);
        checkOutput("miss_req", {31'b0, mem_req}, 32'd0);
        addr_log.delete();
        fetchLine("cold", 32'hBFC00000, 32'h00000013, 4);
        checkOutput("cold_beats", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < addr_log.size())
                checkOutput("cold_addr", addr_log[i], 32'hBFC00000 + 32'(4 * i));
        end

        // Sequential hits
        applyStimulus(1'b1, 32'hBFC00004, 1'b0, 1'b0);
        checkOutput("seq1_instr", instr, 32'h00500093);
        checkOutput("seq1_stall", {31'b0, stall}, 32'd0);
        applyStimulus(1'b1, 32'hBFC00008, 1'b0, 1'b0);
        checkOutput("seq2_instr", instr, 32'h00A00113);
        checkOutput("seq2_req", {31'b0, mem_req}, 32'd0);
        applyStimulus(1'b1, 32'hBFC0000C, 1'b0, 1'b0);
        checkOutput("seq3_instr", instr, 32'h002081B3);
        checkOutput("seq3_valid", {31'b0, instr_valid}, 32'd1);

        // Flush in LOOKUP with a fetch that would have hit
        applyStimulus(1'b1, 32'hBFC00004, 1'b1, 1'b0);
        checkOutput("lflush_stall", {31'b0, stall}, 32'd1);
        checkOutput("lflush_valid", {31'b0, instr_valid}, 32'd0);
        fetchLine("postflush", 32'hBFC00004, 32'h00500093, 5);

        // Conflict misses on set 0
        addr_log.delete();
        fetchLine("conf", 32'hBFC00100, 32'hCFC00100, 5);
        checkOutput("conf_first", addr_log[0], 32'hBFC00100);
        checkOutput("conf_last", addr_log[3], 32'hBFC0010C);
        addr_log.delete();
        fetchLine("back", 32'hBFC00000, 32'h00000013, 5);
        checkOutput("back_first", addr_log[0], 32'hBFC00000);

        // Backpressure: four-cycle memory
        mem_lat = 4;
        fetchLine("slow", 32'hBFC00040, 32'hCFC00040, 17);
        applyStimulus(1'b1, 32'hBFC00048, 1'b0, 1'b0);
        checkOutput("slow_hit", instr, 32'hCFC00048);
        applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b0);
        checkOutput("other_set", instr, 32'h00000013);
        mem_lat = 1;

        // Flush after two refill words
        fetchLine("pre", 32'hBFC00100, 32'hCFC00100, 5);
        applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hBFC00000, 1'b1, 1'b0);
        checkOutput("rflush_stall", {31'b0, stall}, 32'd1);
        applyStimulus(1'b0, 32'hBFC00000, 1'b0, 1'b0);
        checkOutput("rflush_req", {31'b0, mem_req}, 32'd0);
        checkOutput("rflush_idle", {31'b0, stall}, 32'd0);
        addr_log.delete();
        fetchLine("restart", 32'hBFC00000, 32'h00000013, 5);
        checkOutput("restart_first", addr_log[0], 32'hBFC00000);
        checkOutput("restart_beats", 32'(addr_log.size()), 32'd4);
        fetchLine("evicted", 32'hBFC00100, 32'hCFC00100, 5);

        // Reset during a refill
        fetchLine("keep", 32'hBFC00040, 32'hCFC00040, 5);
        applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b1);
        checkOutput("rrst_req", {31'b0, mem_req}, 32'd0);
        checkOutput("rrst_stall", {31'b0, stall}, 32'd0);
        applyStimulus(1'b0, 32'hBFC00000, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'hBFC00000, 1'b0, 1'b0);
        checkOutput("rrst_idle_req", {31'b0, mem_req}, 32'd0);
        fetchLine("after_rst", 32'hBFC00000, 32'h00000013, 5);
        fetchLine("after_rst2", 32'hBFC00040, 32'hCFC00040, 5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache directly downstream of the program counter register.
- Takes the fetch address and returns the instruction word, combinationally on a hit.
- On a miss it asserts `stall` so the PC holds, then refills a full line from backing instruction memory via a single-outstanding req/valid handshake.
- Supports a one-cycle global invalidate (`flush`).

Parameters:
- `SETS`, default 16: number of cache lines; power of 2, ≥2.
- `WORDS_PER_LINE`, default 4: 32-bit words per line; power of 2, ≥2.

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `pc` input 32: fetch address; bits [1:0] ignored.
- `fetch` input 1: fetch request valid this cycle.
- `flush` input 1: invalidate all lines.
- `instr` output 32: instruction word; valid only when `instr_valid`=1.
- `instr_valid` output 1: hit, `instr` usable this cycle.
- `stall` output 1: PC must hold its value this cycle.
- `mem_req` output 1: backing-memory read request.
- `mem_addr` output 32: word-aligned read address.
- `mem_rdata` input 32: read data.
- `mem_rvalid` input 1: `mem_rdata` valid; meaningful only while `mem_req`=1.

Behaviour:
- Address split, with O=log2(`WORDS_PER_LINE`) and S=log2(`SETS`):
  - word offset = `pc`[O+1:2]
  - index = `pc`[O+S+1:O+2]
  - tag = `pc`[31:O+S+2]
  - defaults: offset [3:2], index [7:4], tag [31:8].
- Storage, all flops: valid bit per set; tag per set; data array `SETS`×`WORDS_PER_LINE`×32.
- FSM states: LOOKUP, REFILL.
- Reset (`rst`=1 at posedge):
  - all valid bits cleared; state←LOOKUP; refill word counter←0.
  - While `rst` is high, `mem_req`, `instr_valid` and `stall` are forced to 0. `instr` is don't-care.
- LOOKUP:
  - hit = `fetch` & valid[index] & (tag[index]==tag(`pc`)).
  - hit: `instr_valid`=1, `instr`=data[index][offset], `stall`=0, same cycle (0 latency).
  - `fetch`=0: `instr_valid`=0, `stall`=0.
  - miss (`fetch`=1, not hit): `instr_valid`=0, `stall`=1.
  - On a miss: latch refill line base = {`pc`[31:O+2], O+2 zero bits}; counter←0; valid[index]←0; next state REFILL.
- REFILL:
  - `stall`=1, `instr_valid`=0, `mem_req`=1.
  - `mem_addr` = line base + 4×counter; held stable until `mem_rvalid`.
  - On `mem_rvalid`=1 (same cycle as `mem_req` allowed): data[idx][counter]←`mem_rdata`; counter increments.
  - On the last word (counter=`WORDS_PER_LINE`−1 with `mem_rvalid`): also tag[idx]←latched tag, valid[idx]←1, state←LOOKUP.
  - The next LOOKUP cycle re-evaluates the current `pc`. It normally hits, so miss penalty = `WORDS_PER_LINE`×mem latency + 1 cycle.
  - Refill always fills words 0..N−1 in order; no critical-word-first.
- `mem_req` is 0 in LOOKUP. Exactly one request outstanding at any time.
- `flush`:
  - Highest priority after `rst`. At posedge, clears all valid bits.
  - In REFILL: aborts the refill, state←LOOKUP, counter←0, `mem_req` drops the next cycle, and any `mem_rvalid` in the flush cycle is discarded. The partially written line stays invalid.
  - `stall`=1 in the flush cycle if `fetch`=1.
- `fetch`, `pc` and `flush` are sampled only in LOOKUP, except that `flush` is also honoured in REFILL. `pc` changes during REFILL are ignored.
- A refill of set i never disturbs other sets. Conflict misses overwrite the line in place.

Test Plan:
1. Cold miss then hit:
   - After reset, `fetch`=1, `pc`=0xBFC00000 → `stall`=1; `mem_req` with `mem_addr` 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C in order.
   - 1-cycle mem returns 0x00000013, 0x00500093, 0x00A00113, 0x002081B3.
   - Next cycle: `instr_valid`=1, `instr`=0x00000013.
2. Sequential hits: `pc` stepping 0xBFC00004→0xBFC0000C → `instr` 0x00500093, 0x00A00113, 0x002081B3 on consecutive cycles; `stall`=0 and `mem_req`=0 throughout.
3. Conflict miss:
   - `pc`=0xBFC00100 (same index 0, tag differs) → refill from 0xBFC00100..0x10C.
   - Then `pc`=0xBFC00000 → miss again, refetches 0xBFC00000.
4. Memory backpressure: `mem_rvalid` delayed 3 cycles per word → `mem_addr` held stable each wait; total `stall` = 4×4+1 cycles; correct data returned.
5. Flush mid-refill:
   - `flush`=1 after 2 words received → `mem_req`=0 next cycle, state LOOKUP.
   - Re-fetch of 0xBFC00000 restarts refill at word 0.
   - Previously hit line 0xBFC00100 now misses.
6. Reset mid-refill: `rst`=1 during REFILL → `mem_req`=0; after release, `pc`=0xBFC00000 misses (all lines invalid).
